// File: rtl/adder_pkg.sv
// Shared types and constants for the sequential chunked adder/subtractor.
package adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int unsigned FLAG_OVF  = 0;
  localparam int unsigned FLAG_ZERO = 1;
  localparam int unsigned FLAG_NEG  = 2;
  localparam int unsigned FLAGS_W   = 3;

endpackage

// File: rtl/chunk_add.sv
// CHUNK-bit combinational adder with carry-in, carry-out and the carry into its MSB.
module chunk_add #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             msb_carry
);

  logic [CHUNK:0] full;

  always_comb begin
    full      = {1'b0, x} + {1'b0, y} + (CHUNK+1)'(cin);
    sum       = full[CHUNK-1:0];
    cout      = full[CHUNK];
    // Carry into the top bit recovered from the sum bit and its two operand bits.
    msb_carry = full[CHUNK-1] ^ x[CHUNK-1] ^ y[CHUNK-1];
  end

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor, one CHUNK-bit slice per clock.
// Optional status flags {negative, zero, overflow} when ADDER_FLAGS_EN is defined.
module seq_chunk_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                op_sub,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    result,
  output logic                carry_out
`ifdef ADDER_FLAGS_EN
  ,
  output logic [FLAGS_W-1:0]  flags
`endif
);

  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N - 1);
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0]  result_d;
  logic              carry_out_d;
  logic              busy_d;
  logic              done_d;

  int unsigned       shamt;
  logic [CHUNK-1:0]  slice_a;
  logic [CHUNK-1:0]  slice_b;
  logic [CHUNK-1:0]  slice_sum;
  logic              slice_cout;
  logic [WIDTH-1:0]  merged;

`ifdef ADDER_FLAGS_EN
  logic [FLAGS_W-1:0] flags_d;
  logic               msb_carry;
`else
  logic               unused_msb_carry;
`endif

  // Slice select: the active slice is shifted down to bit 0 for the shared adder.
  always_comb begin
    shamt   = 32'(idx_q) * CHUNK;
    slice_a = CHUNK'(a_q >> shamt);
    slice_b = CHUNK'(b_q >> shamt);
  end

  chunk_add #(
    .CHUNK (CHUNK)
  ) u_chunk_add (
    .x         (slice_a),
    .y         (slice_b),
    .cin       (carry_q),
    .sum       (slice_sum),
    .cout      (slice_cout),
`ifdef ADDER_FLAGS_EN
    .msb_carry (msb_carry)
`else
    .msb_carry (unused_msb_carry)
`endif
  );

  always_comb begin
    merged = (result & ~(SLICE_MASK << shamt)) | (WIDTH'(slice_sum) << shamt);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    result_d    = result;
    carry_out_d = carry_out;
    busy_d      = busy;
    done_d      = 1'b0;
`ifdef ADDER_FLAGS_EN
    flags_d     = flags;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          a_d     = a;
          b_d     = (op_sub == OP_ADD) ? b : ~b;
          carry_d = (op_sub == OP_SUB);
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      BUSY: begin
        result_d = merged;
        carry_d  = slice_cout;
        if (idx_q == LAST_IDX) begin
          state_d     = IDLE;
          idx_d       = '0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          carry_out_d = slice_cout;
`ifdef ADDER_FLAGS_EN
          flags_d[FLAG_NEG]  = merged[WIDTH-1];
          flags_d[FLAG_ZERO] = (merged == '0);
          flags_d[FLAG_OVF]  = msb_carry ^ slice_cout;
`endif
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef ADDER_FLAGS_EN
      flags     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      carry_q   <= carry_d;
      idx_q     <= idx_d;
      result    <= result_d;
      carry_out <= carry_out_d;
      busy      <= busy_d;
      done      <= done_d;
`ifdef ADDER_FLAGS_EN
      flags     <= flags_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed self-checking bench for seq_chunk_adder (CHUNK=8 and CHUNK=32 instances).
// Flag checks are compiled in when ADDER_FLAGS_EN is defined.
module tb_seq_chunk_adder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        op_sub = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry_out;

  logic        start2 = 1'b0;
  logic        op_sub2 = 1'b0;
  logic [31:0] a2 = '0;
  logic [31:0] b2 = '0;
  logic        busy2;
  logic        done2;
  logic [31:0] result2;
  logic        carry_out2;

`ifdef ADDER_FLAGS_EN
  logic [2:0]  flags;
  logic [2:0]  flags2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out)
`ifdef ADDER_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  seq_chunk_adder #(.WIDTH(32), .CHUNK(32)) dut_wide (
    .clk       (clk),
    .reset     (reset),
    .start     (start2),
    .op_sub    (op_sub2),
    .a         (a2),
    .b         (b2),
    .busy      (busy2),
    .done      (done2),
    .result    (result2),
    .carry_out (carry_out2)
`ifdef ADDER_FLAGS_EN
    ,
    .flags     (flags2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present an operation for one edge, then scramble the inputs.
  task automatic launch(input logic sub, input logic [31:0] x, input logic [31:0] y);
    start  = 1'b1;
    op_sub = sub;
    a      = x;
    b      = y;
    @(posedge clk);
    #1;
    start  = 1'b0;
    op_sub = ~sub;
    a      = $urandom;
    b      = $urandom;
  endtask

  // Counts edges until done is seen, bounded.
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!done && cyc < 20);
  endtask

  task automatic run_op(input string tag, input logic sub, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp_res, input logic exp_c);
    int cyc;
    launch(sub, x, y);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(cyc);
    check({tag, "_lat"}, 32'(cyc), 32'd4);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_cout"}, 32'(carry_out), 32'(exp_c));
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int cyc;
    int done_seen;

    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_res", result, 32'h0);
    check("rst_cout", 32'(carry_out), 32'd0);
    #10 reset = 1'b0;
    @(posedge clk);
    #1;

    run_op("add53", 1'b0, 32'd5, 32'd3, 32'h0000_0008, 1'b0);
`ifdef ADDER_FLAGS_EN
    check("add53_flags", 32'(flags), 32'b000);
`endif
    // done holds for exactly one cycle
    @(posedge clk);
    #1;
    check("done_pulse", 32'(done), 32'd0);
    check("res_hold", result, 32'h0000_0008);

    run_op("sub57", 1'b1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0);
`ifdef ADDER_FLAGS_EN
    check("sub57_flags", 32'(flags), 32'b100);
`endif
    run_op("sub75", 1'b1, 32'd7, 32'd5, 32'h0000_0002, 1'b1);
    run_op("wrap", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1'b1);
`ifdef ADDER_FLAGS_EN
    check("wrap_flags", 32'(flags), 32'b010);
`endif
    run_op("ovf", 1'b0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0);
`ifdef ADDER_FLAGS_EN
    check("ovf_flags", 32'(flags), 32'b101);
`endif

    // Back-to-back: start during the done cycle is accepted.
    check("b2b_done_now", 32'(done), 32'd1);
    run_op("b2b", 1'b0, 32'h0102_0304, 32'h1010_1010, 32'h1112_1314, 1'b0);

    // Starts during BUSY cycles 1 and 2 are ignored.
    launch(1'b0, 32'h0000_0010, 32'h0000_0020);
    start = 1'b1; op_sub = 1'b1; a = 32'hAAAA_AAAA; b = 32'h5555_5555;
    @(posedge clk);
    #1;
    start = 1'b1; op_sub = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc);
    check("ign_lat", 32'(cyc), 32'd2);
    check("ign_res", result, 32'h0000_0030);
    @(posedge clk);
    #1;
    check("ign_no_requeue", 32'(busy), 32'd0);

    // Asynchronous reset in BUSY cycle 2.
    launch(1'b0, 32'd5, 32'd3);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_res", result, 32'h0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    check("arst_no_done", 32'(done_seen), 32'd0);
    check("arst_idle", 32'(busy), 32'd0);

    // Single-slice instance: latency 1.
    start2 = 1'b1; op_sub2 = 1'b0; a2 = 32'h1234_5678; b2 = 32'h1111_1111;
    @(posedge clk);
    #1;
    start2 = 1'b0; a2 = '0; b2 = '0;
    check("wide_busy", 32'(busy2), 32'd1);
    @(posedge clk);
    #1;
    check("wide_done", 32'(done2), 32'd1);
    check("wide_res", result2, 32'h2345_6789);
    check("wide_cout", 32'(carry_out2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_chunk_adder.md
# seq_chunk_adder

Parametrised, multi-cycle integer adder/subtractor for the datapath. It is the successor of the single-cycle 32-bit address adder. It processes WIDTH-bit operands in CHUNK-bit slices, one slice per clock, so a wide add meets timing on the multi-cycle clock. Operations are started with a start/busy/done handshake, and the block produces carry-out and, optionally, status flags for branch evaluation.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 8, slice width added per cycle; 1 ≤ CHUNK ≤ WIDTH.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only while idle.
- op_sub  in  1  0 = a+b, 1 = a−b; sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when the result is valid.
- result  out  WIDTH  sum/difference; held until the next accepted start.
- carry_out  out  1  final carry (subtract: 1 = no borrow, i.e. a ≥ b unsigned).
- flags  out  3  {negative, zero, overflow}; present only with ADDER_FLAGS_EN.

## Operation
- N = WIDTH/CHUNK slices; slice i covers bits [i·CHUNK +: CHUNK].
- FSM has two states, IDLE and BUSY.
- IDLE with start=1: latch a, latch b (or ~b when op_sub=1), set carry = op_sub, set idx = 0, go to BUSY. busy rises, done clears.
- IDLE with start=0: hold all outputs; done is cleared after its one pulse cycle.
- BUSY, every edge:
  - result slice idx = a_slice + b_slice + carry; carry ← slice carry-out; idx++.
  - At idx = N−1: carry_out ← final carry, flags update, go to IDLE, busy=0, done=1.
- start while BUSY: ignored; latched operands are unaffected; there is no queueing.
- start in the same cycle done=1: accepted normally (back-to-back operation).
- Arithmetic is modulo 2^WIDTH. overflow = (carry into MSB) XOR (carry out of MSB), i.e. two's-complement overflow. zero = (result == 0). negative = result[WIDTH−1].
- result bits are written slice by slice and are not valid while busy=1; consumers qualify with done.
- Reset, including mid-operation: aborts immediately and returns to IDLE. result=0, carry_out=0, busy=0, done=0, flags=0, idx=0, internal operand registers=0.

## Timing
- start sampled at edge k. busy=1 from k until edge k+N. done=1 for exactly the cycle after edge k+N.
- Latency is N cycles from the start edge to done, giving throughput of one operation per N cycles.
- CHUNK = WIDTH gives latency 1 (single BUSY cycle).
- Inputs a, b and op_sub may change freely after the start edge.
- result, carry_out and flags are registered outputs, stable from the done cycle until the next accepted start's first slice update.

## Configuration
- ADDER_FLAGS_EN defined: the flags port exists; overflow, zero and negative are registered at completion.
- ADDER_FLAGS_EN undefined: the flags port and its logic are removed. carry_out and all timing are unchanged.

## Structure
- Shared package adder_pkg holds:
  - state typedef (IDLE, BUSY);
  - op encoding constants OP_ADD=1'b0, OP_SUB=1'b1;
  - flag bit index constants FLAG_OVF=0, FLAG_ZERO=1, FLAG_NEG=2.
- One sub-module, chunk_add: a CHUNK-bit combinational adder with carry-in, carry-out and MSB carry-in (for overflow). It is instantiated once and muxed by idx.
- The top level holds the FSM, idx counter, operand/result registers and flag logic.

## Test plan
- WIDTH=32, CHUNK=8: a=5, b=3, add → done at start+4 cycles, result=0x00000008, carry_out=0, flags=000.
- Subtract a=5, b=7 → result=0xFFFFFFFE, carry_out=0, negative=1, overflow=0.
- Add a=0xFFFFFFFF, b=1 → result=0, carry_out=1, zero=1. Also a=0x7FFFFFFF, b=1 → result=0x80000000, overflow=1, negative=1.
- start pulsed at cycles 1 and 2 of BUSY with different operands → ignored, original result delivered. start asserted during done → second operation accepted, done again 4 cycles later.
- reset asserted at BUSY cycle 2 → busy=0, done=0, result=0 immediately (asynchronous); no done pulse follows.
- CHUNK=32: a=0x12345678, b=0x11111111 → done one cycle after start, result=0x23456789.
